// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive-path bit decoder: line/run constants,
// the per-bit classification type and the NRZI decode helper.
package usb_rx_pkg;

    localparam int   USB_RUN_LEN = 6;
    localparam logic USB_J_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        BIT_DATA    = 2'd0,
        BIT_STUFFED = 2'd1,
        BIT_ERR     = 2'd2
    } rx_bit_kind_t;

    // No transition on the line decodes as 1, a transition as 0.
    function automatic logic nrzi_decode(input logic line_lvl, input logic ref_lvl);
        return ~(line_lvl ^ ref_lvl);
    endfunction

endpackage

// File: rtl/usb_run_counter.sv
// Consecutive-ones counter with synchronous clear; saturates at RUN_LEN and
// flags when the limit has been reached.
module usb_run_counter
    import usb_rx_pkg::*;
#(
    parameter int    RUN_LEN = USB_RUN_LEN,
    localparam int   CW      = $clog2(RUN_LEN + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] run_cnt,
    output logic          at_limit
);

    logic [CW-1:0] cnt_r;
    logic          at_limit_s;

    assign at_limit_s = (cnt_r == CW'(RUN_LEN));
    assign run_cnt    = cnt_r;
    assign at_limit   = at_limit_s;

    // Run length register: clear wins over increment, increment stops at the limit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && !at_limit_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/usb_nrzi_unstuff.sv
// USB receive NRZI decoder with bit-unstuffing: flags stuffed bits for the
// shift register to skip and raises a sticky error on an over-long run of ones.
module usb_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int    RUN_LEN    = USB_RUN_LEN,
    parameter logic  IDLE_LEVEL = USB_J_LEVEL,
    parameter bit    UNSTUFF_EN = 1'b1,
    localparam int   CW         = $clog2(RUN_LEN + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          d_plus,
    input  logic          shift_enable,
    input  logic          eop,
    output logic          d_orig,
    output logic          bit_valid,
    output logic          stuffed,
    output logic          stuff_err,
    output logic [CW-1:0] run_cnt
);

    logic         prev_r;
    logic         d_orig_r;
    logic         bit_valid_r;
    logic         stuffed_r;
    logic         stuff_err_r;
    logic         bit_s;
    logic         at_limit_s;
    logic         inc_s;
    logic         clr_s;
    rx_bit_kind_t kind_s;

    usb_run_counter #(
        .RUN_LEN (RUN_LEN)
    ) u_run_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .inc      (inc_s),
        .clr      (clr_s),
        .run_cnt  (run_cnt),
        .at_limit (at_limit_s)
    );

    // Decode the current sample and classify it; derive counter controls.
    always_comb begin
        bit_s  = nrzi_decode(d_plus, prev_r);
        kind_s = BIT_DATA;
        inc_s  = 1'b0;
        clr_s  = 1'b0;
        if (UNSTUFF_EN && at_limit_s) begin
            kind_s = bit_s ? BIT_ERR : BIT_STUFFED;
        end else begin
            kind_s = BIT_DATA;
        end
        if (shift_enable && eop) begin
            clr_s = 1'b1;
        end else if (shift_enable) begin
            case (kind_s)
                BIT_DATA: begin
                    inc_s = bit_s;
                    clr_s = ~bit_s;
                end
                BIT_STUFFED, BIT_ERR: clr_s = 1'b1;
                default:              clr_s = 1'b1;
            endcase
        end else begin
            inc_s = 1'b0;
            clr_s = 1'b0;
        end
    end

    // Line reference and output registers; pulses are single-cycle by default.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_r      <= IDLE_LEVEL;
            d_orig_r    <= 1'b1;
            bit_valid_r <= 1'b0;
            stuffed_r   <= 1'b0;
            stuff_err_r <= 1'b0;
        end else begin
            bit_valid_r <= 1'b0;
            stuffed_r   <= 1'b0;
            if (shift_enable && eop) begin
                prev_r      <= IDLE_LEVEL;
                d_orig_r    <= 1'b1;
                stuff_err_r <= 1'b0;
            end else if (shift_enable) begin
                prev_r   <= d_plus;
                d_orig_r <= bit_s;
                case (kind_s)
                    BIT_DATA:    bit_valid_r <= 1'b1;
                    BIT_STUFFED: stuffed_r   <= 1'b1;
                    BIT_ERR: begin
                        bit_valid_r <= 1'b1;
                        stuff_err_r <= 1'b1;
                    end
                    default:     bit_valid_r <= 1'b0;
                endcase
            end else begin
                prev_r      <= prev_r;
                d_orig_r    <= d_orig_r;
                stuff_err_r <= stuff_err_r;
            end
        end
    end

    assign d_orig    = d_orig_r;
    assign bit_valid = bit_valid_r;
    assign stuffed   = stuffed_r;
    assign stuff_err = stuff_err_r;

endmodule

// File: tb/tb_usb_nrzi_unstuff.sv
// Bench for usb_nrzi_unstuff: directed scenarios plus randomized line traffic,
// compared against a bit-level behavioural model of decode and unstuffing.
module tb_usb_nrzi_unstuff;

    localparam int RUN = 6;
    localparam int CW  = $clog2(RUN + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic          d_plus;
    logic          shift_enable;
    logic          eop;
    logic          d_orig, bit_valid, stuffed, stuff_err;
    logic [CW-1:0] run_cnt;
    logic          d_orig_raw, bit_valid_raw, stuffed_raw, stuff_err_raw;
    logic [CW-1:0] run_cnt_raw;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic m_prev, m_d, m_bv, m_st, m_err, m_bv_raw;
    int   m_cnt;
    int   raw_pulses;

    usb_nrzi_unstuff #(.RUN_LEN(RUN), .IDLE_LEVEL(1'b1), .UNSTUFF_EN(1'b1)) u_dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .shift_enable(shift_enable), .eop(eop),
        .d_orig(d_orig), .bit_valid(bit_valid), .stuffed(stuffed), .stuff_err(stuff_err),
        .run_cnt(run_cnt)
    );

    usb_nrzi_unstuff #(.RUN_LEN(RUN), .IDLE_LEVEL(1'b1), .UNSTUFF_EN(1'b0)) u_dut_raw (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .shift_enable(shift_enable), .eop(eop),
        .d_orig(d_orig_raw), .bit_valid(bit_valid_raw), .stuffed(stuffed_raw),
        .stuff_err(stuff_err_raw), .run_cnt(run_cnt_raw)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b1; m_d = 1'b1; m_bv = 1'b0; m_st = 1'b0; m_err = 1'b0;
        m_bv_raw = 1'b0; m_cnt = 0;
    endtask

    task automatic compare_all();
        check_val("d_orig",        {31'd0, d_orig},        {31'd0, m_d});
        check_val("bit_valid",     {31'd0, bit_valid},     {31'd0, m_bv});
        check_val("stuffed",       {31'd0, stuffed},       {31'd0, m_st});
        check_val("stuff_err",     {31'd0, stuff_err},     {31'd0, m_err});
        check_val("run_cnt",       32'(run_cnt),           32'(m_cnt));
        check_val("raw_d_orig",    {31'd0, d_orig_raw},    {31'd0, m_d});
        check_val("raw_bit_valid", {31'd0, bit_valid_raw}, {31'd0, m_bv_raw});
        check_val("raw_stuffed",   {31'd0, stuffed_raw},   32'd0);
        check_val("raw_stuff_err", {31'd0, stuff_err_raw}, 32'd0);
    endtask

    // One clock of stimulus, model update at the edge, compare just after it.
    task automatic step(input logic sh, input logic e, input logic dp);
        logic b;
        @(negedge clk);
        shift_enable = sh; eop = e; d_plus = dp;
        @(posedge clk);
        if (sh && !e) begin
            b        = ~(dp ^ m_prev);
            m_prev   = dp;
            m_d      = b;
            m_bv_raw = 1'b1;
            if (m_cnt < RUN) begin
                m_bv  = 1'b1;
                m_st  = 1'b0;
                m_cnt = b ? m_cnt + 1 : 0;
            end else begin
                m_cnt = 0;
                if (!b) begin
                    m_st = 1'b1; m_bv = 1'b0;
                end else begin
                    m_err = 1'b1; m_bv = 1'b1; m_st = 1'b0;
                end
            end
        end else if (sh && e) begin
            m_prev = 1'b1; m_d = 1'b1; m_cnt = 0; m_err = 1'b0;
            m_bv = 1'b0; m_st = 1'b0; m_bv_raw = 1'b0;
        end else begin
            m_bv = 1'b0; m_st = 1'b0; m_bv_raw = 1'b0;
        end
        #1;
        compare_all();
        if (bit_valid_raw === 1'b1) raw_pulses++;
    endtask

    // Send a wanted decoded bit value by choosing the line level.
    task automatic send_bit(input logic b);
        step(1'b1, 1'b0, b ? m_prev : ~m_prev);
    endtask

    initial begin
        n_rst = 1'b0; shift_enable = 1'b0; eop = 1'b0; d_plus = 1'b1;
        raw_pulses = 0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        n_rst = 1'b1;

        // Constant line: three decoded ones
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check_val("tp1_run_cnt", 32'(run_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b0);

        // Line 1,0,0,1 from idle decodes 1,0,1,0
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_val("tp2_d_orig", {31'd0, d_orig}, 32'd0);
        check_val("tp2_run_cnt", 32'(run_cnt), 32'd0);
        step(1'b1, 1'b1, 1'b0);

        // Six ones then a stuffed zero, then a normal one
        for (int i = 0; i < RUN; i++) send_bit(1'b1);
        check_val("tp3_at_limit", 32'(run_cnt), 32'(RUN));
        send_bit(1'b0);
        check_val("tp3_stuffed", {31'd0, stuffed}, 32'd1);
        check_val("tp3_bv", {31'd0, bit_valid}, 32'd0);
        send_bit(1'b1);
        check_val("tp3_next_cnt", 32'(run_cnt), 32'd1);
        step(1'b1, 1'b1, 1'b0);

        // Seven ones: sticky error, cleared by eop with shift
        for (int i = 0; i < RUN + 1; i++) send_bit(1'b1);
        check_val("tp4_err", {31'd0, stuff_err}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_val("tp4_err_sticky", {31'd0, stuff_err}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check_val("tp4_err_clr", {31'd0, stuff_err}, 32'd0);

        // eop without shift holds state
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        check_val("tp5_hold_cnt", 32'(run_cnt), 32'd3);

        // Asynchronous reset mid-run with the error flag set
        for (int i = 0; i < RUN + 2; i++) send_bit(1'b1);
        check_val("tp5_pre_err", {31'd0, stuff_err}, 32'd1);
        @(negedge clk);
        shift_enable = 1'b0;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_val("rst_d_orig", {31'd0, d_orig}, 32'd1);
        check_val("rst_run_cnt", 32'(run_cnt), 32'd0);
        check_val("rst_err", {31'd0, stuff_err}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Ten decoded ones on the pure decoder
        raw_pulses = 0;
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check_val("tp6_raw_pulses", 32'(raw_pulses), 32'd10);
        step(1'b1, 1'b1, 1'b0);

        // Randomized traffic biased toward long runs of ones
        for (int i = 0; i < 3000; i++) begin
            logic sh, e, dp;
            sh = ($urandom_range(0, 3) != 0);
            e  = ($urandom_range(0, 40) == 0);
            dp = ($urandom_range(0, 5) != 0) ? m_prev : ~m_prev;
            step(sh, e, dp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
